// File: rtl/shift_pkg.sv
// Shared types for the rotate/unrotate datapath: op encoding, sequencer
// states and op decode/inversion helpers.
package shift_pkg;

   localparam int unsigned DEF_WIDTH = 32'd7;

   typedef enum logic [1:0] {
      SH_NONE  = 2'b00,
      SH_RIGHT = 2'b01,
      SH_LEFT  = 2'b10
   } shift_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } unshift_state_t;

   // Raw 2-bit op field; 2'b11 carries no rotation.
   function automatic shift_op_t decode_op(input logic [1:0] op);
      shift_op_t res;
      case (op)
         2'b01:   res = SH_RIGHT;
         2'b10:   res = SH_LEFT;
         default: res = SH_NONE;
      endcase
      return res;
   endfunction

   function automatic shift_op_t invert_op(input shift_op_t op);
      shift_op_t res;
      case (op)
         SH_RIGHT: res = SH_LEFT;
         SH_LEFT:  res = SH_RIGHT;
         default:  res = SH_NONE;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/rot_step.sv
// Combinational single-position rotator, same op encoding as the ALU rotate unit.
module rot_step
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] d,
   input  shift_op_t        op,
   output logic [WIDTH-1:0] q
);

   // Select one-bit rotation by op
   always_comb begin
      case (op)
         SH_RIGHT: q = {d[0], d[WIDTH-1:1]};
         SH_LEFT:  q = {d[WIDTH-2:0], d[WIDTH-1]};
         default:  q = d;
      endcase
   end

endmodule

// File: rtl/unshifter_seq.sv
// Sequential restorer: undoes an n-step rotate by rotating the opposite way,
// one position per clock, with valid/ready on both sides.
module unshifter_seq
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
   input  logic [CNT_W-1:0] in_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   unshift_state_t   state_r;
   shift_op_t        op_r;
   shift_op_t        in_op_s;
   shift_op_t        inv_op_s;
   logic [WIDTH-1:0] data_r;
   logic [WIDTH-1:0] rot_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] eff_cnt_s;

   // Decode request op and derive the effective rotation count
   always_comb begin
      in_op_s  = decode_op(in_op);
      inv_op_s = invert_op(op_r);
      if (in_op_s == SH_NONE) begin
         eff_cnt_s = {CNT_W{1'b0}};
      end else begin
         eff_cnt_s = in_count;
      end
   end

   rot_step #(.WIDTH(WIDTH)) u_rot (
      .d  (data_r),
      .op (inv_op_s),
      .q  (rot_s)
   );

   // Sequencer: accept, rotate one step per clock, hold result until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         op_r      <= SH_NONE;
         data_r    <= {WIDTH{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= {WIDTH{1'b0}};
         busy      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  data_r   <= in_data;
                  op_r     <= in_op_s;
                  cnt_r    <= eff_cnt_s;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (eff_cnt_s != {CNT_W{1'b0}}) begin
                     state_r <= RUN;
                  end else begin
                     state_r   <= DONE;
                     out_valid <= 1'b1;
                     out_data  <= in_data;
                  end
               end
            end
            RUN: begin
               data_r <= rot_s;
               cnt_r  <= cnt_r - CNT_ONE;
               if (cnt_r == CNT_ONE) begin
                  state_r   <= DONE;
                  out_valid <= 1'b1;
                  out_data  <= rot_s;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r   <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state_r   <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unshifter_seq.sv
// Directed bench for unshifter_seq with an expected-result scoreboard queue.
module tb_unshifter_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_data;
   logic [1:0] in_op;
   logic [2:0] in_count;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] out_data;
   logic       busy;

   typedef struct {
      logic [6:0] data;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   unshifter_seq #(.WIDTH(7), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_op     (in_op),
      .in_count  (in_count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Original word, given a word the encoder rotated n times in direction op.
   function automatic logic [6:0] restore(input logic [1:0] op, input logic [2:0] n, input logic [6:0] d);
      logic [13:0] dd;
      int          k;
      dd = {d, d};
      k  = int'(n) % 7;
      if (op == 2'b01) return 7'(dd >> (7 - k));
      else if (op == 2'b10) return 7'(dd >> k);
      else return d;
   endfunction

   task automatic run_job(input logic [1:0] op, input logic [2:0] cnt, input logic [6:0] data,
                          input logic [6:0] exp_data, input int stall, input bit pulse);
      exp_t e;
      exp_t got;
      int   k;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      e.data = exp_data;
      e.lat  = (op == 2'b01 || op == 2'b10) ? int'(cnt) : 0;
      sb.push_back(e);
      in_valid = 1'b1; in_op = op; in_count = cnt; in_data = data;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      k = 0;
      while (!out_valid && k < 40) begin
         check("in_ready_run", {31'd0, in_ready}, 32'd0);
         if (pulse) begin
            in_valid = 1'b1;
            in_data  = ~data;
         end
         @(posedge clk); #1;
         k++;
      end
      in_valid = 1'b0;
      check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
      check("in_ready_done", {31'd0, in_ready}, 32'd0);
      if (sb.size() > 0) begin
         got = sb.pop_front();
         check("out_data", {25'd0, out_data}, {25'd0, got.data});
         check("latency", k, got.lat);
      end else begin
         check("scoreboard_underflow", 32'd1, 32'd0);
      end
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check("stall_valid", {31'd0, out_valid}, 32'd1);
         check("stall_data", {25'd0, out_data}, {25'd0, exp_data});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("valid_drop", {31'd0, out_valid}, 32'd0);
      check("in_ready_back", {31'd0, in_ready}, 32'd1);
      check("busy_drop", {31'd0, busy}, 32'd0);
      check("data_held", {25'd0, out_data}, {25'd0, exp_data});
   endtask

   initial begin
      logic [1:0] rop;
      logic [2:0] rcnt;
      logic [6:0] rdat;
      rst = 1'b1; in_valid = 1'b0; in_data = 7'd0; in_op = 2'b00; in_count = 3'd0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_out_data", {25'd0, out_data}, 32'd0);
      #2 rst = 1'b0;

      run_job(2'b10, 3'd1, 7'b0101101, 7'b1010110, 0, 1'b0);
      run_job(2'b01, 3'd1, 7'b0101011, 7'b1010110, 0, 1'b0);
      run_job(2'b01, 3'd3, 7'b1101010, 7'b1010110, 0, 1'b1);
      run_job(2'b00, 3'd5, 7'b0011001, 7'b0011001, 0, 1'b0);
      run_job(2'b10, 3'd7, 7'b0011001, 7'b0011001, 0, 1'b1);
      run_job(2'b11, 3'd4, 7'b0011001, 7'b0011001, 0, 1'b0);
      run_job(2'b01, 3'd2, 7'b1000001, 7'b0000110, 4, 1'b0);
      run_job(2'b10, 3'd6, 7'b1110001, restore(2'b10, 3'd6, 7'b1110001), 0, 1'b0);

      for (int j = 0; j < 6; j++) begin
         rop  = 2'($urandom_range(3, 0));
         rcnt = 3'($urandom_range(7, 0));
         rdat = 7'($urandom_range(127, 0));
         run_job(rop, rcnt, rdat, restore(rop, rcnt, rdat), j % 2, 1'b0);
      end

      // Reset during the second RUN cycle of a count-5 job.
      in_valid = 1'b1; in_op = 2'b01; in_count = 3'd5; in_data = 7'b1010101;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_out_data", {25'd0, out_data}, 32'd0);
      @(posedge clk); #1;
      check("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
      #2 rst = 1'b0;
      run_job(2'b10, 3'd2, 7'b1100000, 7'b0011000, 0, 1'b0);

      check("scoreboard_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/unshifter_seq.md
Name: unshifter_seq

Overview:
- Sequential inverse of the team's 7-bit single-step rotate unit.
- Accepts a word that was rotated `count` times in direction `op`, and restores the original word by rotating the opposite way, one bit per clock.
- Sits downstream of the ALU rotate path as its decoder or restorer. Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 7, data word width in bits.
- CNT_W, 3, width of the rotate-count field. Counts 0..2^CNT_W-1 are legal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  WIDTH  rotated word to restore.
- in_op  input  2  direction the encoder applied: 00 = none, 01 = right, 10 = left, 11 = none.
- in_count  input  CNT_W  number of encoder rotations applied.
- out_valid  output  1  restored word available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  restored word.
- busy  output  1  high while in RUN or DONE.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high, acting on posedge clk or posedge rst.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, busy = 0, internal count = 0, stored op = 00.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On edge E with in_valid & in_ready, latch in_data, in_op and in_count.
  - Effective count n = in_count if in_op is 01 or 10; n = 0 if in_op is 00 or 11.
  - Next state is RUN if n > 0, else DONE.
- RUN:
  - Each edge, rotate the data register one position inverse to op and decrement the count.
  - op 01 (right) → rotate left: {d[W-2:0], d[W-1]}.
  - op 10 (left) → rotate right: {d[0], d[W-1:1]}.
  - When the count is 1 at the edge, rotate and enter DONE.
- Latency: out_valid rises after edge E+n, where E is the accept edge. So n = 0 gives 1 cycle, and n = 7 enters DONE 7 edges after accept.
- DONE:
  - out_valid = 1; out_data = register, held stable while out_ready = 0.
  - On an edge with out_valid & out_ready, go to IDLE. in_ready rises the cycle after.
- No overlap: in_ready = 0 in RUN and DONE. in_valid is ignored there, with no queuing and no error.
- Rotation is modular. n = WIDTH returns the input unchanged after WIDTH cycles; no clamping.
- out_data stays at the last result after leaving DONE until the next result. It is only meaningful while out_valid = 1.
- Reset mid-RUN or mid-DONE: immediate return to reset values and the pending result is discarded. The first accept is possible on the first rising edge after rst deasserts.
- Outputs are registered or decoded from state only. There is no combinational path from in_* to out_*.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] shift_op_t {SH_NONE = 2'b00, SH_RIGHT = 2'b01, SH_LEFT = 2'b10}; 2'b11 is treated as SH_NONE.
  - typedef enum unshift_state_t {IDLE, RUN, DONE}.
  - Constant DEF_WIDTH = 7.
- One sub-module, rot_step: a combinational, WIDTH-parameterized single-bit rotator with shift_op_t select, using the same encoding as the ALU rotate unit.
  - unshifter_seq instantiates it with the inverted op: RIGHT↔LEFT, NONE→NONE.

Test Plan:
- Left, count 1: in_op=10, in_count=1, in_data=7'b0101101 → out_data=7'b1010110. out_valid rises 1 edge after accept.
- Right, count 1: in_op=01, in_count=1, in_data=7'b0101011 → out_data=7'b1010110.
- Right, count 3: in_op=01, in_count=3, in_data=7'b1101010 → out_data=7'b1010110, out_valid after edge E+3. Also check in_ready=0 through RUN/DONE, and that in_valid pulses during RUN are ignored.
- Zero and wrap counts:
  - in_op=00, in_count=5, in_data=7'b0011001 → out_data unchanged, latency 1.
  - in_op=10, in_count=7, same data → unchanged after 7 edges.
  - in_op=11 → treated as none.
- Backpressure: hold out_ready=0 for 4 cycles in DONE → out_valid and out_data stable. Raise out_ready → IDLE next edge, and a back-to-back accept is possible the following edge.
- Reset mid-operation: assert rst asynchronously (between edges) at RUN cycle 2 of a count-5 job → outputs go to reset values immediately, with no spurious out_valid. A new job after release completes correctly.
